// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words and writes them to consecutive instruction-memory addresses while holding the core.
module imem_loader #(
  parameter int PC_SIZE   = 10,
  parameter int ADDR_STEP = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [PC_SIZE:0]   num_words,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               rw,
  output logic               reset_IF_memory,
  output logic [PC_SIZE-1:0] PC_write,
  output logic [31:0]        instruction_in,
  output logic               core_hold,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RECV  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [PC_SIZE-1:0] ADDR_INC = PC_SIZE'(ADDR_STEP);
  localparam logic [PC_SIZE:0]   WORDS_ONE = {{PC_SIZE{1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 start_ok_s;
  logic                 accept_s;
  logic [PC_SIZE-1:0]   addr_r;
  logic [PC_SIZE:0]     words_left_r;
  logic [1:0]           byte_cnt_r;
  logic [31:0]          word_r;
  logic                 byte_ready_r;
  logic                 rw_r;
  logic                 clr_r;
  logic [PC_SIZE-1:0]   pc_write_r;
  logic [31:0]          instr_r;
  logic                 core_hold_r;
  logic                 busy_r;
  logic                 done_r;

  // byte_ready_r is high exactly while in RECV, so it alone qualifies a handshake
  assign accept_s = byte_valid & byte_ready_r & ~abort;

  // Next-state decode; abort overrides every other condition
  always_comb begin
    state_nxt_s = state_r;
    start_ok_s  = 1'b0;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            start_ok_s = 1'b1;
            if (num_words != {(PC_SIZE+1){1'b0}}) begin
              state_nxt_s = ST_CLEAR;
            end else begin
              state_nxt_s = ST_DONE;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_CLEAR: state_nxt_s = ST_RECV;
        ST_RECV: begin
          if (accept_s && (byte_cnt_r == 2'd3)) begin
            state_nxt_s = ST_WRITE;
          end else begin
            state_nxt_s = ST_RECV;
          end
        end
        ST_WRITE: begin
          if (words_left_r == WORDS_ONE) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RECV;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs; outputs are decoded from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= {PC_SIZE{1'b0}};
      words_left_r <= {(PC_SIZE+1){1'b0}};
      byte_cnt_r   <= 2'd0;
      word_r       <= 32'd0;
      byte_ready_r <= 1'b0;
      rw_r         <= 1'b0;
      clr_r        <= 1'b0;
      pc_write_r   <= {PC_SIZE{1'b0}};
      instr_r      <= 32'd0;
      core_hold_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      byte_ready_r <= (state_nxt_s == ST_RECV);
      rw_r         <= (state_nxt_s == ST_WRITE);
      clr_r        <= (state_nxt_s == ST_CLEAR);
      core_hold_r  <= (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_RECV) ||
                      (state_nxt_s == ST_WRITE);
      busy_r       <= (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_RECV) ||
                      (state_nxt_s == ST_WRITE);
      done_r       <= (state_nxt_s == ST_DONE);

      if (start_ok_s) begin
        words_left_r <= num_words;
      end else if (!abort && (state_r == ST_WRITE)) begin
        words_left_r <= words_left_r - WORDS_ONE;
      end else begin
        words_left_r <= words_left_r;
      end

      if (state_nxt_s == ST_CLEAR) begin
        addr_r <= {PC_SIZE{1'b0}};
      end else if (!abort && (state_r == ST_WRITE)) begin
        addr_r <= addr_r + ADDR_INC;
      end else begin
        addr_r <= addr_r;
      end

      // A partially assembled word is dropped by restarting the byte lane on abort
      if (abort || (state_nxt_s == ST_CLEAR)) begin
        byte_cnt_r <= 2'd0;
      end else if (accept_s) begin
        byte_cnt_r                          <= byte_cnt_r + 2'd1;
        word_r[{byte_cnt_r, 3'b000} +: 8]   <= byte_in;
      end else begin
        byte_cnt_r <= byte_cnt_r;
      end

      if (state_nxt_s == ST_WRITE) begin
        pc_write_r <= addr_r;
        instr_r    <= {byte_in, word_r[23:0]};
      end else begin
        pc_write_r <= pc_write_r;
        instr_r    <= instr_r;
      end
    end
  end

  assign byte_ready      = byte_ready_r;
  assign rw              = rw_r;
  assign reset_IF_memory = clr_r;
  assign PC_write        = pc_write_r;
  assign instruction_in  = instr_r;
  assign core_hold       = core_hold_r;
  assign busy            = busy_r;
  assign done            = done_r;

endmodule
